// File: rtl/clk_en_scheduler_pkg.sv
// Shared definitions for the slow-clock scheduler: config FSM state
// encodings, system clock rate, and a helper that turns a wanted base-tick
// rate into a prescaler length.
package clk_en_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cfg_state_e;

  localparam int unsigned CLK_HZ = 100_000_000;

  // System clock cycles per base tick for a requested base rate in Hz.
  // A zero rate is clamped to a tick every cycle rather than dividing by zero.
  function automatic int unsigned prescale_for(input int unsigned rate_hz);
    if (rate_hz == 0) return 1;
    return CLK_HZ / rate_hz;
  endfunction

endpackage

// File: rtl/clk_en_scheduler_channel.sv
// One scheduler channel: divides the shared base tick into a tick pulse per
// half-period and a 50% duty clock enable.
// Ports: basys_clk/rst_n; step_i (base tick), load_i + load_div_i/load_en_i
// (runtime reconfiguration, wins over step_i); tick_o, clk_out_o (registered).
module clk_en_scheduler_channel
  import clk_en_scheduler_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 25
) (
  input  logic             basys_clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_div_i,
  input  logic             load_en_i,
  output logic             tick_o,
  output logic             clk_out_o
);

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic [DIV_W-1:0] last_cnt;

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  assign last_cnt = (div_q == '0) ? '0 : div_q - 1'b1;

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    en_d   = en_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (load_i) begin
      // Reload restarts the half-period without a tick; the square wave
      // keeps its level when staying enabled so there is no glitch.
      cnt_d = '0;
      div_d = load_div_i;
      en_d  = load_en_i;
      if (!load_en_i) clk_d = 1'b0;
    end else if (!en_q) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (step_i) begin
      if (cnt_q == last_cnt) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DEF_DIV_V;
      en_q   <= 1'b1;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      en_q   <= en_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_q;

endmodule

// File: rtl/clk_en_scheduler.sv
// Shared slow-clock scheduler: one prescaler makes a base tick that NUM_CH
// programmable channels divide into tick pulses and square-wave enables.
// Ports: basys_clk/rst_n; cfg_valid/cfg_ready with cfg_ch/cfg_div/cfg_en
// (one request in flight, applied on the next base tick); base_tick, tick[],
// clk_out[] registered outputs.
module clk_en_scheduler
  import clk_en_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PRESCALE = prescale_for(1000),
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DEF_DIV  = 25,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              basys_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int unsigned       PCNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  // ---------------- prescaler ----------------
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              base_tick_q, base_tick_d;

  always_comb begin
    pcnt_d      = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
    base_tick_d = (pcnt_q == PCNT_LAST);
  end

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      base_tick_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      base_tick_q <= base_tick_d;
    end
  end

  assign base_tick = base_tick_q;

  // ---------------- config FSM ----------------
  cfg_state_e       state_q, state_d;
  logic [CH_W-1:0]  pend_ch_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_en_q;
  logic             accept;
  logic             apply;

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_valid) state_d = ST_PEND;
      ST_PEND: if (base_tick_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A request accepted in a base-tick cycle is still in IDLE on that edge,
  // so it is naturally applied on the following base tick.
  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    apply     = (state_q == ST_PEND) && base_tick_q;
  end

  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      pend_en_q  <= 1'b0;
    end else if (accept) begin
      pend_ch_q  <= cfg_ch;
      pend_div_q <= cfg_div;
      pend_en_q  <= cfg_en;
    end
  end

  // ---------------- channels ----------------
  // An out-of-range channel index matches no instance, so it is a no-op.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = apply && (pend_ch_q == CH_W'(i));

    clk_en_scheduler_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .basys_clk  (basys_clk),
      .rst_n      (rst_n),
      .step_i     (base_tick_q),
      .load_i     (load),
      .load_div_i (pend_div_q),
      .load_en_i  (pend_en_q),
      .tick_o     (tick[i]),
      .clk_out_o  (clk_out[i])
    );
  end

endmodule

// File: tb/tb_clk_en_scheduler.sv
module tb_clk_en_scheduler;

  localparam int NCH = 3;

  logic           basys_clk = 1'b0;
  logic           rst_n     = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch    = '0;
  logic [15:0]    cfg_div   = '0;
  logic           cfg_en    = 1'b0;
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;

  clk_en_scheduler #(
    .NUM_CH   (NCH),
    .PRESCALE (4),
    .DIV_W    (16),
    .DEF_DIV  (3)
  ) dut (
    .basys_clk (basys_clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .base_tick (base_tick),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  always #5 basys_clk = ~basys_clk;

  // Cycle index: value k is seen between the k-th and (k+1)-th rising edge
  // after reset release.
  int cyc;
  always @(posedge basys_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int   at;
    logic lvl;
  } ev_t;

  ev_t exp_q[NCH][$];
  int  errors = 0;
  int  checks = 0;

  task automatic push_ev(input int c, input int at, input logic lvl);
    ev_t e;
    e.at  = at;
    e.lvl = lvl;
    exp_q[c].push_back(e);
  endtask

  // Default-rate timeline from reset release: every channel ticks at cycles
  // 13, 25, 37, 49 with clk_out going 1, 0, 1, 0.
  task automatic push_default_timeline();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 4; k++) push_ev(c, 13 + 12 * k, (k % 2 == 0));
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(negedge basys_clk);
      guard++;
    end while (cyc != n && guard < 2000);
    #1;
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic drain_check(input string name);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++;
        $display("FAIL %s ch%0d: %0d expected ticks never seen (next at %0d)",
                 name, c, exp_q[c].size(), exp_q[c][0].at);
        exp_q[c].delete();
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge basys_clk);
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset cfg_ready got=%b exp=1", cfg_ready); end
    checks++;
    if (base_tick !== 1'b0) begin errors++; $display("FAIL reset base_tick got=%b exp=0", base_tick); end
    checks++;
    if (tick !== 3'b000) begin errors++; $display("FAIL reset tick got=%b exp=000", tick); end
    checks++;
    if (clk_out !== 3'b000) begin errors++; $display("FAIL reset clk_out got=%b exp=000", clk_out); end
    push_default_timeline();
    rst_n = 1'b1;
  endtask

  task automatic test_default_rate();
    wait_cyc(24);
    checks++;
    if (clk_out !== 3'b111) begin errors++; $display("FAIL default clk_out@24 got=%b exp=111", clk_out); end
    wait_cyc(36);
    checks++;
    if (clk_out !== 3'b000) begin errors++; $display("FAIL default clk_out@36 got=%b exp=000", clk_out); end
    wait_cyc(50);
    drain_check("default_rate");
  endtask

  // At cycle 50: ch1 -> div 2, applied at edge 53 with clk_out held low.
  task automatic test_retune();
    push_ev(0, 61, 1'b1); push_ev(0, 73, 1'b0); push_ev(0, 85, 1'b1);
    push_ev(2, 61, 1'b1); push_ev(2, 73, 1'b0); push_ev(2, 85, 1'b1);
    push_ev(1, 61, 1'b1); push_ev(1, 69, 1'b0); push_ev(1, 77, 1'b1); push_ev(1, 85, 1'b0);
    cfg_ch = 2'd1; cfg_div = 16'd2; cfg_en = 1'b1; cfg_valid = 1'b1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL retune ready@50 got=%b exp=1", cfg_ready); end
    wait_cyc(51);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL retune ready@51 got=%b exp=0", cfg_ready); end
    wait_cyc(52);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL retune ready@52 got=%b exp=0", cfg_ready); end
    wait_cyc(53);
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL retune ready@53 got=%b exp=1", cfg_ready); end
    checks++;
    if (clk_out[1] !== 1'b0) begin errors++; $display("FAIL retune clk_out1@53 got=%b exp=0", clk_out[1]); end
    wait_cyc(88);
    drain_check("retune");
  endtask

  // At cycle 88 (a base-tick cycle) gate ch2 while its clk_out is high; the
  // request must wait for the base tick at cycle 92 and land on edge 93.
  task automatic test_gate();
    push_ev(0, 97, 1'b0); push_ev(0, 109, 1'b1); push_ev(0, 121, 1'b0);
    push_ev(1, 93, 1'b1); push_ev(1, 101, 1'b0); push_ev(1, 109, 1'b1);
    push_ev(1, 117, 1'b0); push_ev(1, 125, 1'b1);
    checks++;
    if (clk_out[2] !== 1'b1) begin errors++; $display("FAIL gate clk_out2@88 got=%b exp=1", clk_out[2]); end
    cfg_ch = 2'd2; cfg_div = 16'd3; cfg_en = 1'b0; cfg_valid = 1'b1;
    wait_cyc(89);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL gate ready@89 got=%b exp=0", cfg_ready); end
    wait_cyc(92);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL gate ready@92 got=%b exp=0", cfg_ready); end
    checks++;
    if (clk_out[2] !== 1'b1) begin errors++; $display("FAIL gate clk_out2@92 got=%b exp=1", clk_out[2]); end
    wait_cyc(93);
    checks++;
    if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL gate clk_out2@93 got=%b exp=0", clk_out[2]); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL gate ready@93 got=%b exp=1", cfg_ready); end
    wait_cyc(129);
    checks++;
    if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL gate clk_out2@129 got=%b exp=0", clk_out[2]); end
    drain_check("gate");
  endtask

  // At cycle 129: ch0 div 0 behaves as div 1, tick every base tick.
  task automatic test_div_zero();
    push_ev(0, 137, 1'b1); push_ev(0, 141, 1'b0); push_ev(0, 145, 1'b1); push_ev(0, 149, 1'b0);
    push_ev(1, 133, 1'b0); push_ev(1, 141, 1'b1); push_ev(1, 149, 1'b0);
    cfg_ch = 2'd0; cfg_div = 16'd0; cfg_en = 1'b1; cfg_valid = 1'b1;
    wait_cyc(130);
    cfg_valid = 1'b0;
    wait_cyc(133);
    checks++;
    if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL divzero clk_out0@133 got=%b exp=0", clk_out[0]); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL divzero ready@133 got=%b exp=1", cfg_ready); end
    wait_cyc(152);
    drain_check("div_zero");
  endtask

  task automatic test_invalid_ch();
    push_ev(0, 153, 1'b1); push_ev(0, 157, 1'b0); push_ev(0, 161, 1'b1); push_ev(0, 165, 1'b0);
    push_ev(1, 157, 1'b1); push_ev(1, 165, 1'b0);
    wait_cyc(153);
    cfg_ch = 2'd3; cfg_div = 16'd7; cfg_en = 1'b0; cfg_valid = 1'b1;
    wait_cyc(154);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL invalid ready@154 got=%b exp=0", cfg_ready); end
    wait_cyc(156);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL invalid ready@156 got=%b exp=0", cfg_ready); end
    wait_cyc(157);
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL invalid ready@157 got=%b exp=1", cfg_ready); end
    wait_cyc(168);
    checks++;
    if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL invalid clk_out2@168 got=%b exp=0", clk_out[2]); end
    drain_check("invalid_ch");
  endtask

  task automatic test_reset_mid_pend();
    push_ev(0, 169, 1'b1);
    wait_cyc(169);
    cfg_ch = 2'd1; cfg_div = 16'd5; cfg_en = 1'b0; cfg_valid = 1'b1;
    wait_cyc(170);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midpend ready@170 got=%b exp=0", cfg_ready); end
    drain_check("pre_reset");
    rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midpend reset cfg_ready got=%b exp=1", cfg_ready); end
    checks++;
    if (clk_out !== 3'b000) begin errors++; $display("FAIL midpend reset clk_out got=%b exp=000", clk_out); end
    checks++;
    if (tick !== 3'b000) begin errors++; $display("FAIL midpend reset tick got=%b exp=000", tick); end
    checks++;
    if (base_tick !== 1'b0) begin errors++; $display("FAIL midpend reset base_tick got=%b exp=0", base_tick); end
    push_default_timeline();
    @(negedge basys_clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(24);
    checks++;
    if (clk_out !== 3'b111) begin errors++; $display("FAIL midpend clk_out@24 got=%b exp=111", clk_out); end
    wait_cyc(50);
    drain_check("reset_mid_pend");
  endtask

  initial begin
    fork
      begin : scoreboard
        ev_t  e;
        logic exp_bt;
        forever begin
          @(negedge basys_clk);
          if (rst_n) begin
            exp_bt = (cyc > 0) && (cyc % 4 == 0);
            checks++;
            if (base_tick !== exp_bt) begin
              errors++;
              $display("FAIL base_tick cyc=%0d got=%b exp=%b", cyc, base_tick, exp_bt);
            end
            for (int c = 0; c < NCH; c++) begin
              if (tick[c] === 1'b1) begin
                checks++;
                if (exp_q[c].size() == 0) begin
                  errors++;
                  $display("FAIL tick ch%0d unexpected at cyc=%0d", c, cyc);
                end else begin
                  e = exp_q[c].pop_front();
                  if (e.at != cyc || clk_out[c] !== e.lvl) begin
                    errors++;
                    $display("FAIL tick ch%0d got cyc=%0d clk_out=%b exp cyc=%0d clk_out=%b",
                             c, cyc, clk_out[c], e.at, e.lvl);
                  end
                end
              end else if (exp_q[c].size() > 0 && exp_q[c][0].at <= cyc) begin
                checks++;
                errors++;
                e = exp_q[c].pop_front();
                $display("FAIL tick ch%0d missing: tick=%b at cyc=%0d exp pulse at %0d",
                         c, tick[c], cyc, e.at);
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_default_rate();
    test_retune();
    test_gate();
    test_div_zero();
    test_invalid_ch();
    test_reset_mid_pend();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
